morse_keyer: RTL
================

MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter UNIT_TICKS, default 4: clock cycles per Morse time unit; legal range 1..65535.
REQ-002 Parameter LETTER_GAP, default 3: key-up units appended after every character; legal range 1..15.
REQ-003 Parameter WORD_GAP, default 4: key-up units emitted for a space (0x20); legal range 1..15.
REQ-004 Parameter CASE_FOLD, default 1: 1 = lowercase 0x61..0x7A is accepted as the matching uppercase letter; 0 = lowercase is unsupported.
REQ-005 clk  input  1  single system clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_char holds a character to transmit.
REQ-008 in_char  input  7  ASCII code.
REQ-009 in_ready  output  1  block can accept a character this cycle.
REQ-010 key_out  output  1  registered keying line: 1 = tone on.
REQ-011 busy  output  1  registered; 1 from the cycle after acceptance through the last gap cycle.
REQ-012 char_done  output  1  one-cycle pulse when a character (or space) has completed its trailing gap.
REQ-013 bad_char  output  1  one-cycle pulse when an unsupported code is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, KEY and GAP; in_ready SHALL equal (state==IDLE) AND rst_n.
REQ-015 Acceptance SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_char SHALL be captured at that edge, and later changes SHALL be ignored until the next acceptance.
REQ-016 An internal table SHALL encode A-Z and 0-9 (ITU Morse) as a unit pattern (dot = 1 on-unit, dash = 3 on-units, 1 off-unit between elements, no trailing off-unit), MSB first: max 19 bits, plus a 5-bit unit length (e.g. E = "1"/1, A = "10111"/5, 0 = 19 units).
REQ-017 On accepting a supported letter or digit, the FSM SHALL go to KEY, and key_out SHALL present pattern bit k for exactly UNIT_TICKS cycles, k = MSB..LSB, starting the cycle after acceptance.
REQ-018 After the last pattern unit the FSM SHALL go to GAP, holding key_out=0 for LETTER_GAP*UNIT_TICKS cycles.
REQ-019 On accepting 0x20 the FSM SHALL go directly to GAP for WORD_GAP*UNIT_TICKS cycles, with key_out=0 throughout.
REQ-020 Total busy time SHALL be (len+LETTER_GAP)*UNIT_TICKS cycles for a character and WORD_GAP*UNIT_TICKS cycles for a space.
REQ-021 On the first cycle after the last GAP cycle the FSM SHALL be in IDLE, with char_done=1 for that single cycle and in_ready=1, so back-to-back acceptance is possible in that cycle.
REQ-022 On accepting an unsupported code (including lowercase when CASE_FOLD=0) the FSM SHALL stay in IDLE, pulse bad_char the following cycle, keep key_out=0 and busy=0, and pulse no char_done.
REQ-023 The unit tick counter SHALL be $clog2(UNIT_TICKS)+1 bits wide and wrap to 0 at UNIT_TICKS-1; with UNIT_TICKS=1 every cycle SHALL be one unit.
REQ-024 key_out SHALL never be 1 outside the KEY state.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, key_out=0, busy=0, char_done=0, bad_char=0, in_ready=0, and all counters and the shift register cleared.
REQ-026 A reset asserted mid-character SHALL abort that character with no char_done; the first edge after release SHALL be IDLE with in_ready=1.

Verification
REQ-027 UNIT_TICKS=2, LETTER_GAP=3: accept 0x45 at cycle 0 -> key_out=1 in cycles 1-2, 0 in cycles 3-8; busy=1 in cycles 1-8; char_done=1 and in_ready=1 in cycle 9.
REQ-028 UNIT_TICKS=1, LETTER_GAP=3: accept 0x41 at cycle 0 -> key_out = 1,0,1,1,1 in cycles 1-5, 0 in cycles 6-8, char_done in cycle 9.
REQ-029 UNIT_TICKS=2, WORD_GAP=4: accept 0x20 -> key_out=0 and busy=1 for 8 cycles, then char_done pulses once.
REQ-030 CASE_FOLD=1: accept 0x61 -> waveform identical to 0x41; CASE_FOLD=0: accept 0x61, then 0x23 -> bad_char pulses once each, key_out stays 0.
REQ-031 Hold in_valid=1 with "SOS" (0x53, 0x4F, 0x53) presented in sequence -> three acceptances, each in its char_done cycle, with no idle cycle between characters; total (5+3 + 11+3 + 5+3)*UNIT_TICKS busy cycles.
REQ-032 Drive rst_n=0 mid-dash of 0x30 -> key_out falls immediately without waiting for a clock edge, no char_done; after release, accept 0x45 -> normal REQ-027 timing.

Source files
------------

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character at a time and keys it as ITU Morse
// on key_out, followed by a letter gap (or a word gap for a space).
module morse_keyer #(
  parameter int UNIT_TICKS = 4,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 4,
  parameter bit CASE_FOLD  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] in_char,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       bad_char,
  output logic [1:0] state_dbg
);

  localparam int TW = $clog2(UNIT_TICKS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [4:0]      units, units_n;
  logic [17:0]     shift, shift_n;
  logic            key_n, busy_n, done_n, bad_n;
  logic [24:0]     look;
  logic            unit_end;

  // Returns {supported, unit length, unit pattern left-aligned in 19 bits}.
  // Table entries list elements in transmit order, dash = 1.
  function automatic logic [24:0] lookup(input logic [6:0] code);
    logic [6:0]  c;
    logic [2:0]  n;
    logic [4:0]  bits;
    logic [4:0]  len;
    logic [18:0] pat;
    logic        sup;
    c = code;
    if (CASE_FOLD && (c >= 7'h61) && (c <= 7'h7A)) c = c - 7'h20;
    sup  = 1'b1;
    n    = 3'd0;
    bits = 5'b0;
    case (c)
      7'h41: begin n = 3'd2; bits = 5'b01;    end
      7'h42: begin n = 3'd4; bits = 5'b1000;  end
      7'h43: begin n = 3'd4; bits = 5'b1010;  end
      7'h44: begin n = 3'd3; bits = 5'b100;   end
      7'h45: begin n = 3'd1; bits = 5'b0;     end
      7'h46: begin n = 3'd4; bits = 5'b0010;  end
      7'h47: begin n = 3'd3; bits = 5'b110;   end
      7'h48: begin n = 3'd4; bits = 5'b0000;  end
      7'h49: begin n = 3'd2; bits = 5'b00;    end
      7'h4A: begin n = 3'd4; bits = 5'b0111;  end
      7'h4B: begin n = 3'd3; bits = 5'b101;   end
      7'h4C: begin n = 3'd4; bits = 5'b0100;  end
      7'h4D: begin n = 3'd2; bits = 5'b11;    end
      7'h4E: begin n = 3'd2; bits = 5'b10;    end
      7'h4F: begin n = 3'd3; bits = 5'b111;   end
      7'h50: begin n = 3'd4; bits = 5'b0110;  end
      7'h51: begin n = 3'd4; bits = 5'b1101;  end
      7'h52: begin n = 3'd3; bits = 5'b010;   end
      7'h53: begin n = 3'd3; bits = 5'b000;   end
      7'h54: begin n = 3'd1; bits = 5'b1;     end
      7'h55: begin n = 3'd3; bits = 5'b001;   end
      7'h56: begin n = 3'd4; bits = 5'b0001;  end
      7'h57: begin n = 3'd3; bits = 5'b011;   end
      7'h58: begin n = 3'd4; bits = 5'b1001;  end
      7'h59: begin n = 3'd4; bits = 5'b1011;  end
      7'h5A: begin n = 3'd4; bits = 5'b1100;  end
      7'h30: begin n = 3'd5; bits = 5'b11111; end
      7'h31: begin n = 3'd5; bits = 5'b01111; end
      7'h32: begin n = 3'd5; bits = 5'b00111; end
      7'h33: begin n = 3'd5; bits = 5'b00011; end
      7'h34: begin n = 3'd5; bits = 5'b00001; end
      7'h35: begin n = 3'd5; bits = 5'b00000; end
      7'h36: begin n = 3'd5; bits = 5'b10000; end
      7'h37: begin n = 3'd5; bits = 5'b11000; end
      7'h38: begin n = 3'd5; bits = 5'b11100; end
      7'h39: begin n = 3'd5; bits = 5'b11110; end
      default: sup = 1'b0;
    endcase
    // Expand elements: dot = 1, dash = 111, single 0 between elements.
    bits = bits << (3'd5 - n);
    pat  = '0;
    len  = '0;
    for (int i = 0; i < 5; i++) begin
      if (3'(i) < n) begin
        if (i > 0) begin
          pat = {pat[17:0], 1'b0};
          len = len + 5'd1;
        end
        if (bits[4]) begin
          pat = {pat[15:0], 3'b111};
          len = len + 5'd3;
        end else begin
          pat = {pat[17:0], 1'b1};
          len = len + 5'd1;
        end
        bits = {bits[3:0], 1'b0};
      end
    end
    pat = pat << (5'd19 - len);
    return {sup, len, pat};
  endfunction

  assign in_ready  = (state == IDLE) && rst_n;
  assign state_dbg = state;
  assign unit_end  = (tick == TW'(UNIT_TICKS - 1));

  // The unit counter counts remaining units minus one in both KEY and GAP.
  always_comb begin
    state_n = state;
    tick_n  = tick;
    units_n = units;
    shift_n = shift;
    key_n   = key_out;
    busy_n  = busy;
    done_n  = 1'b0;
    bad_n   = 1'b0;
    look    = lookup(in_char);
    case (state)
      IDLE: begin
        if (in_valid) begin
          tick_n = '0;
          if (in_char == 7'h20) begin
            state_n = GAP;
            busy_n  = 1'b1;
            key_n   = 1'b0;
            units_n = 5'(WORD_GAP - 1);
          end else if (look[24]) begin
            state_n = KEY;
            busy_n  = 1'b1;
            key_n   = look[18];
            shift_n = look[17:0];
            units_n = look[23:19] - 5'd1;
          end else begin
            bad_n = 1'b1;
          end
        end
      end
      KEY: begin
        if (unit_end) begin
          tick_n = '0;
          if (units == 5'd0) begin
            state_n = GAP;
            key_n   = 1'b0;
            units_n = 5'(LETTER_GAP - 1);
          end else begin
            units_n = units - 5'd1;
            key_n   = shift[17];
            shift_n = {shift[16:0], 1'b0};
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      GAP: begin
        key_n = 1'b0;
        if (unit_end) begin
          tick_n = '0;
          if (units == 5'd0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            units_n = units - 5'd1;
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        key_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick      <= '0;
      units     <= '0;
      shift     <= '0;
      key_out   <= 1'b0;
      busy      <= 1'b0;
      char_done <= 1'b0;
      bad_char  <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      units     <= units_n;
      shift     <= shift_n;
      key_out   <= key_n;
      busy      <= busy_n;
      char_done <= done_n;
      bad_char  <= bad_n;
    end
  end

endmodule
